// File: rtl/icache_fetch_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-address bits left over once word offset, line index and byte lane are removed.
    function automatic int tag_bits(input int addr_w, input int lines, input int words);
        return addr_w - $clog2(lines) - $clog2(words) - 2;
    endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-side and refill-side signals of the instruction cache bundled as one bus.
interface icache_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_en;
    logic [31:0]       cpu_data;
    logic              stall;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;

    // slave is the cache; master is the pipeline plus backing memory around it.
    modport slave (
        input  cpu_addr, cpu_en, flush, mem_ack, mem_data,
        output cpu_data, stall, mem_req, mem_addr
    );
    modport master (
        output cpu_addr, cpu_en, flush, mem_ack, mem_data,
        input  cpu_data, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fetch_data_ram.sv
// Line data store: asynchronous read for same-cycle hits, synchronous write for refill.
module icache_fetch_data_ram #(
    parameter int IDX_W = 4,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data
);
    logic [31:0] mem [2**(IDX_W+OFF_W)];

    assign rd_data = mem[{rd_idx, rd_off}];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_idx, wr_off}] <= wr_data;
    end
endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only I-cache: zero-latency hits, whole-line refill over a word handshake.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    icache_fetch_if.slave  bus
);
    localparam int OFF_W = off_bits(WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINES, WORDS);

    fill_state_t       state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram [LINES];
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [OFF_W-1:0]  wcnt;
    logic [OFF_W-1:0]  wcnt_nxt;
    logic              flush_pend;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [31:0]       rd_data;
    logic              unused_byte_sel;

    assign off = bus.cpu_addr[OFF_W+1:2];
    assign idx = bus.cpu_addr[OFF_W+2 +: IDX_W];
    assign tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign unused_byte_sel = ^bus.cpu_addr[1:0];

    assign hit          = bus.cpu_en && valid[idx] && (tag_ram[idx] == tag);
    assign bus.cpu_data = hit ? rd_data : 32'd0;
    // Reset forces stall low even with a pending fetch, so the PC is not held during reset.
    assign bus.stall    = !reset && ((state == IDLE) ? (bus.cpu_en && !hit) : 1'b1);

    assign wcnt_nxt = wcnt + 1'b1;

    icache_fetch_data_ram #(
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) u_data_ram (
        .clk     (clk),
        .rd_idx  (idx),
        .rd_off  (off),
        .rd_data (rd_data),
        .we      (state == REFILL && bus.mem_ack),
        .wr_idx  (miss_idx),
        .wr_off  (wcnt),
        .wr_data (bus.mem_data)
    );

    // Tags are only meaningful behind a set valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == FILL_DONE) tag_ram[miss_idx] <= miss_tag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            valid        <= '0;
            miss_tag     <= '0;
            miss_idx     <= '0;
            wcnt         <= '0;
            flush_pend   <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) valid <= '0;
                    if (bus.cpu_en && !hit) begin
                        miss_tag     <= tag;
                        miss_idx     <= idx;
                        wcnt         <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    // The refill always runs to completion; a flush only poisons the result.
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                        valid      <= '0;
                    end
                    if (bus.mem_ack) begin
                        wcnt <= wcnt_nxt;
                        if (wcnt == OFF_W'(WORDS - 1)) begin
                            bus.mem_req <= 1'b0;
                            state       <= FILL_DONE;
                        end else begin
                            bus.mem_addr <= {miss_tag, miss_idx, wcnt_nxt, 2'b00};
                        end
                    end
                end
                FILL_DONE: begin
                    valid[miss_idx] <= !flush_pend;
                    if (bus.flush) valid <= '0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
